medipix_serial_bridge: RTL and testbench
========================================

// Module: medipix_serial_bridge
// PURPOSE
//  Nios-to-Medipix bridge, next generation of the fixed-rate TPSWT toggler.
//  Buffers bytes written by the Nios PIO in a FIFO and serialises them onto the Medipix
//  serial link (clock, data, enable) at a run-time-programmable bit rate, with frame framing.
//  Also generates Out_TPSWT_Mdpx with a parametrised divider and a run-time enable.
//  Sits between the Nios PIO registers and the Medipix chip pins; single clock domain.
// PARAMETERS
//  DATA_W      8   width of one Nios write word / serialised symbol
//  FIFO_DEPTH  16  FIFO entries, power of 2, >=2
//  DIV_W       8   width of In_Div
//  MSB_FIRST   1   1: shift MSB first, 0: LSB first
//  TPSWT_DIV   2   In_Clk cycles per Out_TPSWT_Mdpx half-period, >=1
// PORTS
//  In_Clk           in   1       single system clock, all logic on rising edge
//  In_Reset         in   1       synchronous, active-low reset
//  In_En_nios       in   1       write strobe, one word per cycle when high
//  In_Sync_nios     in   1       sampled with In_En_nios: 1 = this word ends the frame
//  In_Data_nios     in   DATA_W  write data
//  In_Div           in   DIV_W   serial clock half-period in In_Clk cycles (0 treated as 1)
//  In_Tpswt_en      in   1       1 = run TPSWT divider
//  Out_Full         out  1       FIFO full (writes ignored)
//  Out_Overflow     out  1       sticky: write attempted while full; cleared only by reset
//  Out_Busy         out  1       1 whenever FSM not IDLE or FIFO not empty
//  Out_Clk_Mdpx     out  1       serial clock to chip
//  Out_Data_Mdpx    out  1       serial data, changes on Out_Clk_Mdpx falling edge
//  Out_Enable_Mdpx  out  1       high for the whole frame
//  Out_TPSWT_Mdpx   out  1       test-pulse switch square wave
// BEHAVIOUR
//  Reset (In_Reset=0 at a clock edge): all outputs 0, FIFO emptied, FSM->IDLE, counters 0;
//   applies mid-frame: link drops to 0 on the next cycle, in-flight bits discarded.
//  FIFO: entry = {last, data}. Write when In_En_nios && !Out_Full; full write dropped and
//   Out_Overflow set. Simultaneous pop and write on a full FIFO: write dropped (full is registered).
//  Div tick: hp = (In_Div==0)?1:In_Div; counter reloads on FSM leaving IDLE; tick every hp cycles.
//   In_Div is sampled at each reload; changes take effect at the next reload.
//  FSM states IDLE, LOAD, SHIFT, STALL, GAP:
//   IDLE: clk/data/enable 0. FIFO non-empty -> LOAD.
//   LOAD (1 cycle): pop, shift reg <= data, bitcnt <= DATA_W-1, Out_Enable_Mdpx<=1,
//    Out_Data_Mdpx <= first bit -> SHIFT. Enable rises 2 cycles after the first write strobe.
//   SHIFT: each tick toggles Out_Clk_Mdpx. Rising toggle: nothing else. Falling toggle:
//    bitcnt>0 -> present next bit, bitcnt--. bitcnt==0 (byte done): last -> GAP;
//    else FIFO non-empty -> pop and present next word's first bit on same edge (no gap);
//    else -> STALL.
//   STALL: clk low, enable high, data held; FIFO non-empty -> pop, present first bit, reload
//    tick counter -> SHIFT.
//   GAP: clk 0, data 0, enable 0 for 2*hp cycles -> IDLE (frames always separated).
//  One word = 2*DATA_W*hp cycles of link time; first rising clk hp cycles after LOAD.
//  TPSWT: while In_Tpswt_en=1, Out_TPSWT_Mdpx toggles every TPSWT_DIV cycles (period 2*TPSWT_DIV);
//   In_Tpswt_en=0 -> counter cleared, output forced 0 next cycle; restart begins at 0.
// TESTING
//  Write 0xA5 with sync=1, In_Div=1 -> enable high 2 cycles later; data 1,0,1,0,0,1,0,1 on
//   8 rising clks 2 cycles apart; enable low for 2 cycles after last falling edge; Busy then 0.
//  Write 0x81,0x7E (sync on 2nd), In_Div=3 -> 16 contiguous bits, no clock gap between words,
//   clock period 6 cycles, single enable window.
//  Write 0x12 sync=0, wait 100 cycles, write 0x34 sync=1 -> STALL: clk low, enable held high,
//   then 0x34 shifted; one frame.
//  Burst 18 writes while In_Div=255 -> Out_Full after 16 (+1 popped), extra writes dropped,
//   Out_Overflow=1 and stays 1 until reset.
//  Reset asserted mid-bit of frame -> next cycle all outputs 0, FIFO empty; new write framed cleanly.
//  In_Tpswt_en=1, TPSWT_DIV=2 -> Out_TPSWT_Mdpx 0,0,1,1,0,0... ; drop enable -> 0 next cycle.

Source files
------------

// File: rtl/medipix_serial_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : medipix_serial_bridge
//  Description : Buffers Nios PIO words in a FIFO and serialises them onto the
//                Medipix clock/data/enable link at a programmable bit rate,
//                with frame framing. Also generates the TPSWT square wave.
//  Revision    : 1.0 - initial release
// ============================================================================
module medipix_serial_bridge #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int TPSWT_DIV  = 2
) (
    input  logic              In_Clk,
    input  logic              In_Reset,
    input  logic              In_En_nios,
    input  logic              In_Sync_nios,
    input  logic [DATA_W-1:0] In_Data_nios,
    input  logic [DIV_W-1:0]  In_Div,
    input  logic              In_Tpswt_en,
    output logic              Out_Full,
    output logic              Out_Overflow,
    output logic              Out_Busy,
    output logic              Out_Clk_Mdpx,
    output logic              Out_Data_Mdpx,
    output logic              Out_Enable_Mdpx,
    output logic              Out_TPSWT_Mdpx
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int c_TW = (TPSWT_DIV > 1) ? $clog2(TPSWT_DIV) : 1;

    localparam logic [c_BW-1:0]  c_BITS_M1 = c_BW'(DATA_W - 1);
    localparam logic [c_AW:0]    c_DEPTH   = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_TW-1:0]  c_TP_LAST = c_TW'(TPSWT_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_STALL = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // Bit currently at the output end of a word for the configured order.
    function automatic logic f_first_bit(input logic [DATA_W-1:0] d);
        return (MSB_FIRST != 0) ? d[DATA_W-1] : d[0];
    endfunction

    // Word with the presented bit removed, next bit moved to the output end.
    function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] d);
        return (MSB_FIRST != 0) ? (d << 1) : (d >> 1);
    endfunction

    // ------------------------------------------------------------------ FIFO
    logic [DATA_W:0]   r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              r_ovf;
    logic              w_full;
    logic              w_empty;
    logic              w_wr;
    logic              w_pop;
    logic [DATA_W:0]   w_head;
    logic [DATA_W-1:0] w_head_data;
    logic              w_head_last;

    assign w_full      = (r_count == c_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_wr        = In_En_nios && !w_full;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_data = w_head[DATA_W-1:0];
    assign w_head_last = w_head[DATA_W];

    // Storage array: entry is {frame-last flag, data}; no reset needed.
    always_ff @(posedge In_Clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {In_Sync_nios, In_Data_nios};
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge In_Clk) begin
        if (!In_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= r_count + (c_AW + 1)'(w_wr) - (c_AW + 1)'(w_pop);
            if (In_En_nios && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------- serialiser FSM
    state_t            r_state, w_state_n;
    logic              r_clk, w_clk_n;
    logic              r_data, w_data_n;
    logic              r_en, w_en_n;
    logic [DATA_W-1:0] r_shift, w_shift_n;
    logic [c_BW-1:0]   r_bitcnt, w_bitcnt_n;
    logic              r_last, w_last_n;
    logic [DIV_W:0]    r_cnt, w_cnt_n;
    logic [DIV_W-1:0]  r_hp_m1, w_hp_m1_n;
    logic [DIV_W-1:0]  w_div_m1;

    // Half-period minus one taken from In_Div, zero treated as one.
    assign w_div_m1 = (In_Div == '0) ? '0 : (In_Div - DIV_W'(1));

    // State and link datapath registers.
    always_ff @(posedge In_Clk) begin
        if (!In_Reset) begin
            r_state  <= S_IDLE;
            r_clk    <= 1'b0;
            r_data   <= 1'b0;
            r_en     <= 1'b0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_last   <= 1'b0;
            r_cnt    <= '0;
            r_hp_m1  <= '0;
        end else begin
            r_state  <= w_state_n;
            r_clk    <= w_clk_n;
            r_data   <= w_data_n;
            r_en     <= w_en_n;
            r_shift  <= w_shift_n;
            r_bitcnt <= w_bitcnt_n;
            r_last   <= w_last_n;
            r_cnt    <= w_cnt_n;
            r_hp_m1  <= w_hp_m1_n;
        end
    end

    // Next-state and next link values; every pop also loads the head word.
    always_comb begin
        w_state_n  = r_state;
        w_clk_n    = r_clk;
        w_data_n   = r_data;
        w_en_n     = r_en;
        w_shift_n  = r_shift;
        w_bitcnt_n = r_bitcnt;
        w_last_n   = r_last;
        w_cnt_n    = r_cnt;
        w_hp_m1_n  = r_hp_m1;
        w_pop      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_n  = 1'b0;
                w_data_n = 1'b0;
                w_en_n   = 1'b0;
                if (!w_empty) begin
                    w_state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                w_pop     = 1'b1;
                w_en_n    = 1'b1;
                w_clk_n   = 1'b0;
                w_cnt_n   = {1'b0, w_div_m1};
                w_hp_m1_n = w_div_m1;
                w_state_n = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
                    w_cnt_n = {1'b0, r_hp_m1};
                    w_clk_n = ~r_clk;
                    if (r_clk) begin
                        if (r_bitcnt != '0) begin
                            w_data_n   = f_first_bit(r_shift);
                            w_shift_n  = f_shift(r_shift);
                            w_bitcnt_n = r_bitcnt - c_BW'(1);
                        end else if (r_last) begin
                            w_state_n = S_GAP;
                            w_data_n  = 1'b0;
                            w_en_n    = 1'b0;
                            w_cnt_n   = {r_hp_m1, 1'b1};
                        end else if (!w_empty) begin
                            w_pop = 1'b1;
                        end else begin
                            w_state_n = S_STALL;
                        end
                    end
                end else begin
                    w_cnt_n = r_cnt - (DIV_W + 1)'(1);
                end
            end
            S_STALL: begin
                w_clk_n = 1'b0;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_cnt_n   = {1'b0, w_div_m1};
                    w_hp_m1_n = w_div_m1;
                    w_state_n = S_SHIFT;
                end
            end
            S_GAP: begin
                w_clk_n  = 1'b0;
                w_data_n = 1'b0;
                w_en_n   = 1'b0;
                if (r_cnt == '0) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_cnt_n = r_cnt - (DIV_W + 1)'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_clk_n   = 1'b0;
                w_data_n  = 1'b0;
                w_en_n    = 1'b0;
            end
        endcase

        if (w_pop) begin
            w_shift_n  = f_shift(w_head_data);
            w_data_n   = f_first_bit(w_head_data);
            w_last_n   = w_head_last;
            w_bitcnt_n = c_BITS_M1;
        end
    end

    // ---------------------------------------------------------------- TPSWT
    logic [c_TW-1:0] r_tcnt;
    logic            r_tpswt;

    // Free-running square wave while enabled; restarts from 0 when re-enabled.
    always_ff @(posedge In_Clk) begin
        if (!In_Reset || !In_Tpswt_en) begin
            r_tcnt  <= '0;
            r_tpswt <= 1'b0;
        end else if (r_tcnt == c_TP_LAST) begin
            r_tcnt  <= '0;
            r_tpswt <= ~r_tpswt;
        end else begin
            r_tcnt  <= r_tcnt + c_TW'(1);
        end
    end

    assign Out_Full        = w_full;
    assign Out_Overflow    = r_ovf;
    assign Out_Busy        = (r_state != S_IDLE) || !w_empty;
    assign Out_Clk_Mdpx    = r_clk;
    assign Out_Data_Mdpx   = r_data;
    assign Out_Enable_Mdpx = r_en;
    assign Out_TPSWT_Mdpx  = r_tpswt;

endmodule
`default_nettype wire

// File: tb/tb_medipix_serial_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_medipix_serial_bridge
//  Description : Self-checking bench for medipix_serial_bridge: directed
//                timing scenarios plus random frames against a bit-queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_medipix_serial_bridge;

    localparam int TDIV = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_nios = 1'b0;
    logic       sync_nios = 1'b0;
    logic [7:0] data_nios = 8'h00;
    logic [7:0] div = 8'd1;
    logic       tpswt_en = 1'b0;
    logic       full, ovf, busy, clk_o, data_o, en_o, tpswt;

    medipix_serial_bridge #(
        .DATA_W(8), .FIFO_DEPTH(16), .DIV_W(8), .MSB_FIRST(1), .TPSWT_DIV(TDIV)
    ) dut (
        .In_Clk(clk), .In_Reset(rst_n), .In_En_nios(en_nios),
        .In_Sync_nios(sync_nios), .In_Data_nios(data_nios), .In_Div(div),
        .In_Tpswt_en(tpswt_en), .Out_Full(full), .Out_Overflow(ovf),
        .Out_Busy(busy), .Out_Clk_Mdpx(clk_o), .Out_Data_Mdpx(data_o),
        .Out_Enable_Mdpx(en_o), .Out_TPSWT_Mdpx(tpswt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Posedge count: at a negedge, cyc names the edge that just happened.
    always @(posedge clk) cyc++;

    // Captured link traffic and expected traffic.
    bit cap_bits[$];
    int cap_frames[$];
    bit cur_bits[$];
    int rise_cyc[$];
    bit exp_bits[$];
    int exp_frames[$];
    bit pend[$];
    int en_rise_cyc = -1;
    int en_fall_cyc = -1;
    int busy_fall_cyc = -1;
    bit in_rst = 1'b1;
    bit prev_clk = 1'b0, prev_en = 1'b0, prev_busy = 1'b0, prev_data = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Link monitor: bits are taken on rising serial clock inside enable windows.
    always @(negedge clk) begin
        if (in_rst) begin
            cur_bits.delete();
        end else begin
            if (en_o && clk_o && !prev_clk) begin
                cur_bits.push_back(data_o);
                rise_cyc.push_back(cyc);
            end
            if (en_o && !prev_en) en_rise_cyc = cyc;
            if (!en_o && prev_en) begin
                en_fall_cyc = cyc;
                cap_frames.push_back(cur_bits.size());
                foreach (cur_bits[k]) cap_bits.push_back(cur_bits[k]);
                cur_bits.delete();
            end
            if (!busy && prev_busy) busy_fall_cyc = cyc;
            if (!en_o) chk("idle_link", 64'({clk_o, data_o}), 64'(0));
            if (en_o && prev_en && (data_o !== prev_data))
                chk("data_change_on_low_clk", 64'(clk_o), 64'(0));
        end
        prev_clk  = clk_o;
        prev_en   = en_o;
        prev_busy = busy;
        prev_data = data_o;
    end

    task automatic model_push(input logic [7:0] d, input logic s);
        for (int i = 7; i >= 0; i--) pend.push_back(d[i]);
        if (s) begin
            exp_frames.push_back(pend.size());
            foreach (pend[k]) exp_bits.push_back(pend[k]);
            pend.delete();
        end
    endtask

    // One write strobe; c returns the posedge number that samples it.
    task automatic wr(input logic [7:0] d, input logic s, input bit track, output int c);
        en_nios = 1'b1;
        data_nios = d;
        sync_nios = s;
        c = cyc + 1;
        @(negedge clk);
        en_nios = 1'b0;
        if (track) model_push(d, s);
    endtask

    task automatic idle(input int n);
        en_nios = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'(0));
        @(negedge clk);
    endtask

    task automatic clear_all();
        cap_bits.delete();
        cap_frames.delete();
        exp_bits.delete();
        exp_frames.delete();
        pend.delete();
        rise_cyc.delete();
    endtask

    task automatic check_frames(input string tag);
        int ci, ei, n;
        logic [63:0] ov, ev;
        ci = 0;
        ei = 0;
        chk({tag, "_frames"}, 64'(cap_frames.size()), 64'(exp_frames.size()));
        n = (cap_frames.size() < exp_frames.size()) ? cap_frames.size() : exp_frames.size();
        for (int f = 0; f < n; f++) begin
            ov = '0;
            ev = '0;
            for (int k = 0; k < cap_frames[f]; k++) begin ov = {ov[62:0], cap_bits[ci]}; ci++; end
            for (int k = 0; k < exp_frames[f]; k++) begin ev = {ev[62:0], exp_bits[ei]}; ei++; end
            chk({tag, "_len"}, 64'(cap_frames[f]), 64'(exp_frames[f]));
            chk({tag, "_bits"}, ov, ev);
        end
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_outputs", 64'({full, ovf, busy, clk_o, data_o, en_o, tpswt}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_rst = 1'b0;
    endtask

    initial begin
        int w0, w1, bad;
        @(negedge clk);
        do_reset();

        // Single word 0xA5, half-period 1.
        clear_all();
        div = 8'd1;
        wr(8'hA5, 1'b1, 1'b1, w0);
        wait_idle(400);
        check_frames("t1");
        chk("t1_en_rise", 64'(en_rise_cyc), 64'(w0 + 2));
        chk("t1_rises", 64'(rise_cyc.size()), 64'(8));
        if (rise_cyc.size() == 8) begin
            chk("t1_first_rise", 64'(rise_cyc[0]), 64'(w0 + 3));
            bad = 0;
            for (int i = 1; i < 8; i++) if (rise_cyc[i] - rise_cyc[i-1] != 2) bad++;
            chk("t1_period_bad", 64'(bad), 64'(0));
        end
        chk("t1_en_fall", 64'(en_fall_cyc), 64'(w0 + 2 + 16));
        chk("t1_busy_fall", 64'(busy_fall_cyc), 64'(en_fall_cyc + 2));

        // Two contiguous words, half-period 3.
        clear_all();
        div = 8'd3;
        wr(8'h81, 1'b0, 1'b1, w0);
        wr(8'h7E, 1'b1, 1'b1, w1);
        wait_idle(1000);
        check_frames("t2");
        chk("t2_rises", 64'(rise_cyc.size()), 64'(16));
        if (rise_cyc.size() == 16) begin
            chk("t2_first_rise", 64'(rise_cyc[0]), 64'(w0 + 2 + 3));
            bad = 0;
            for (int i = 1; i < 16; i++) if (rise_cyc[i] - rise_cyc[i-1] != 6) bad++;
            chk("t2_period_bad", 64'(bad), 64'(0));
        end
        chk("t2_en_fall", 64'(en_fall_cyc), 64'(w0 + 2 + 96));
        chk("t2_busy_fall", 64'(busy_fall_cyc), 64'(en_fall_cyc + 6));

        // Stall between words of one frame.
        clear_all();
        div = 8'd1;
        wr(8'h12, 1'b0, 1'b1, w0);
        idle(50);
        chk("t3_stall_state", 64'({clk_o, en_o, busy}), 64'(3'b011));
        idle(50);
        wr(8'h34, 1'b1, 1'b1, w1);
        wait_idle(400);
        check_frames("t3");
        chk("t3_rises", 64'(rise_cyc.size()), 64'(16));
        if (rise_cyc.size() == 16)
            chk("t3_resume_rise", 64'(rise_cyc[8]), 64'(w1 + 2));

        // Burst into a slow link: fill, overflow, sticky flag.
        clear_all();
        div = 8'd255;
        for (int i = 0; i < 18; i++) begin
            wr(8'($urandom), (i == 16), 1'b0, w0);
            chk($sformatf("t4_full_%0d", i), 64'(full), 64'(i >= 16));
            chk($sformatf("t4_ovf_%0d", i), 64'(ovf), 64'(i >= 17));
        end
        idle(20);
        chk("t4_ovf_sticky", 64'({ovf, full, en_o}), 64'(3'b111));

        // Reset in the middle of a bit, then a clean frame.
        do_reset();
        clear_all();
        div = 8'd2;
        wr(8'($urandom), 1'b1, 1'b1, w0);
        wait_idle(400);
        check_frames("t5");
        chk("t5_en_rise", 64'(en_rise_cyc), 64'(w0 + 2));

        // Random frames with random rates and random write spacing.
        for (int f = 0; f < 8; f++) begin
            int nw, hp, wf, wx;
            clear_all();
            div = 8'($urandom_range(0, 4));
            hp = (div == 0) ? 1 : int'(div);
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++) begin
                if (w == 0) wr(8'($urandom), (w == nw - 1), 1'b1, wf);
                else        wr(8'($urandom), (w == nw - 1), 1'b1, wx);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 40));
            end
            wait_idle(3000);
            check_frames($sformatf("rnd%0d", f));
            if (rise_cyc.size() > 0)
                chk($sformatf("rnd%0d_first_rise", f), 64'(rise_cyc[0]), 64'(wf + 2 + hp));
            chk($sformatf("rnd%0d_gap", f), 64'(busy_fall_cyc - en_fall_cyc), 64'(2 * hp));
        end

        // TPSWT square wave, stop, restart.
        tpswt_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("tpswt_run_%0d", k), 64'(tpswt), 64'((k / TDIV) % 2));
        end
        tpswt_en = 1'b0;
        @(negedge clk);
        chk("tpswt_stop", 64'(tpswt), 64'(0));
        tpswt_en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk($sformatf("tpswt_restart_%0d", k), 64'(tpswt), 64'((k / TDIV) % 2));
        end
        tpswt_en = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
